// File: rtl/symbol_packer_pkg.sv
// Shared defaults and types for the symbol packer and its output register.
// The mux bench and the packer bench both take their widths from here.
package symbol_packer_pkg;

    localparam int DEF_SYM_W         = 2;
    localparam int DEF_SYMS_PER_WORD = 4;
    localparam int DEF_WORD_W        = DEF_SYM_W * DEF_SYMS_PER_WORD;
    localparam int DEF_CNT_W         = $clog2(DEF_SYMS_PER_WORD);

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/symbol_packer_if.sv
// Symbol-in / word-out handshake bundle of the packer.
// master is the packer side, slave is the surrounding environment.
interface symbol_packer_if
    import symbol_packer_pkg::*;
#(
    parameter int SYM_W         = DEF_SYM_W,
    parameter int SYMS_PER_WORD = DEF_SYMS_PER_WORD
);
    localparam int WORD_W = SYM_W * SYMS_PER_WORD;
    localparam int CNT_W  = $clog2(SYMS_PER_WORD);

    logic [SYM_W-1:0]  data_in;
    logic              valid_in;
    logic              ready_in;
    logic [WORD_W-1:0] data_out;
    logic              valid_out;
    logic              ready_out;
    logic [CNT_W-1:0]  sym_cnt;
    logic              overflow;

    modport master (
        input  data_in, valid_in, ready_out,
        output ready_in, data_out, valid_out, sym_cnt, overflow
    );

    modport slave (
        output data_in, valid_in, ready_out,
        input  ready_in, data_out, valid_out, sym_cnt, overflow
    );

endinterface

// File: rtl/packer_out_reg.sv
// One-entry EMPTY/FULL output register with valid/ready handshake.
// A load while draining replaces the word with no bubble.
module packer_out_reg
    import symbol_packer_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic              ready_out,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out
);

    out_state_e        state_q;
    logic [WORD_W-1:0] word_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OUT_EMPTY;
            word_q  <= '0;
        end else begin
            case (state_q)
                OUT_EMPTY: begin
                    if (load) begin
                        word_q  <= word;
                        state_q <= OUT_FULL;
                    end
                end
                OUT_FULL: begin
                    // Upstream never loads while held (FULL, !ready_out), so data stays stable.
                    if (load) begin
                        word_q  <= word;
                        state_q <= OUT_FULL;
                    end else if (ready_out) begin
                        state_q <= OUT_EMPTY;
                    end
                end
                default: state_q <= OUT_EMPTY;
            endcase
        end
    end

    assign data_out  = word_q;
    assign valid_out = (state_q == OUT_FULL);

endmodule

// File: rtl/symbol_packer.sv
// Packs SYMS_PER_WORD symbols LSB-first into a word, back-pressuring only when
// the final symbol of a word cannot be handed to a held output register.
module symbol_packer
    import symbol_packer_pkg::*;
#(
    parameter int SYM_W         = DEF_SYM_W,
    parameter int SYMS_PER_WORD = DEF_SYMS_PER_WORD
) (
    input  logic            clk,
    input  logic            reset,
    symbol_packer_if.master bus
);

    localparam int WORD_W = SYM_W * SYMS_PER_WORD;
    localparam int CNT_W  = $clog2(SYMS_PER_WORD);
    localparam int SLOT_W = WORD_W - SYM_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SYMS_PER_WORD - 1);

    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [SLOT_W-1:0] slots_q, slots_d;
    logic              ovf_q,   ovf_d;

    logic              ready_in;
    logic              accept;
    logic              complete;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] data_out_w;
    logic              valid_out_w;

    assign ready_in = !(cnt_q == LAST && valid_out_w && !bus.ready_out);
    assign accept   = bus.valid_in && ready_in;
    assign complete = accept && (cnt_q == LAST);
    assign word     = {bus.data_in, slots_q};

    // Slots are left as-is after completion; cnt_q alone defines occupancy.
    always_comb begin
        cnt_d   = cnt_q;
        slots_d = slots_q;
        ovf_d   = ovf_q;
        if (accept) begin
            if (complete) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                for (int i = 0; i < SYMS_PER_WORD - 1; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        slots_d[i*SYM_W +: SYM_W] = bus.data_in;
                    end
                end
            end
        end
        if (bus.valid_in && !ready_in) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            slots_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            slots_q <= slots_d;
            ovf_q   <= ovf_d;
        end
    end

    packer_out_reg #(
        .WORD_W (WORD_W)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (complete),
        .word      (word),
        .ready_out (bus.ready_out),
        .data_out  (data_out_w),
        .valid_out (valid_out_w)
    );

    assign bus.ready_in  = ready_in;
    assign bus.data_out  = data_out_w;
    assign bus.valid_out = valid_out_w;
    assign bus.sym_cnt   = cnt_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_symbol_packer.sv
// Directed bench for symbol_packer: a reference model builds expected words as
// symbols are sent, and a negedge monitor pops and compares every drained word.
module tb_symbol_packer;
    import symbol_packer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    symbol_packer_if bus ();

    symbol_packer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] sb[$];
    logic [7:0] acc;
    int         nsym;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one symbol for one clock; the model assumes it is accepted.
    task automatic send(input logic [1:0] s);
        bus.valid_in = 1'b1;
        bus.data_in  = s;
        acc[nsym*2 +: 2] = s;
        nsym++;
        if (nsym == 4) begin
            sb.push_back(acc);
            nsym = 0;
        end
        tick();
    endtask

    function automatic logic [1:0] mux2(input logic [1:0] a, input logic [1:0] b, input logic sel);
        return sel ? b : a;
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b0 && bus.valid_out === 1'b1 && bus.ready_out === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_word: observed %0h expected none", bus.data_out);
            end else begin
                check("drained_word", bus.data_out, sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] a, b, s;
        logic       sel;
        acc  = '0;
        nsym = 0;

        // Test 1: reset held two clocks with valid_in high
        reset         = 1'b1;
        bus.valid_in  = 1'b1;
        bus.data_in   = 2'b11;
        bus.ready_out = 1'b0;
        tick();
        tick();
        check("rst_valid_out", bus.valid_out, 1'b0);
        check("rst_sym_cnt",   bus.sym_cnt,   2'd0);
        check("rst_overflow",  bus.overflow,  1'b0);
        check("rst_data_out",  bus.data_out,  8'h00);
        reset        = 1'b0;
        bus.valid_in = 1'b0;

        // Test 2: single word, one-clock valid pulse
        bus.ready_out = 1'b1;
        send(2'b01); send(2'b10); send(2'b11); send(2'b00);
        check("pack_valid",   bus.valid_out, 1'b1);
        check("pack_data",    bus.data_out,  8'h39);
        check("pack_cnt",     bus.sym_cnt,   2'd0);
        bus.valid_in = 1'b0;
        tick();
        check("pack_pulse_end", bus.valid_out, 1'b0);

        // Test 3: 12 mux symbols back to back
        for (int i = 1; i <= 12; i++) begin
            a   = 2'($urandom_range(0, 3));
            b   = 2'($urandom_range(0, 3));
            sel = 1'($urandom_range(0, 1));
            s   = mux2(a, b, sel);
            check("stream_ready_in", bus.ready_in, 1'b1);
            send(s);
            check("stream_valid", bus.valid_out, (i % 4 == 0) ? 1'b1 : 1'b0);
        end
        bus.valid_in = 1'b0;
        tick();
        check("stream_idle", bus.valid_out, 1'b0);

        // Test 4: backpressure with word 8'h39 held
        bus.ready_out = 1'b0;
        send(2'b01); send(2'b10); send(2'b11); send(2'b00);
        check("bp_valid", bus.valid_out, 1'b1);
        check("bp_data",  bus.data_out,  8'h39);
        send(2'b11); send(2'b11); send(2'b11);
        check("bp_cnt",      bus.sym_cnt,  2'd3);
        check("bp_ready_in", bus.ready_in, 1'b0);
        check("bp_hold",     bus.data_out, 8'h39);

        // Test 5: symbols offered during the stall are dropped
        bus.valid_in = 1'b1;
        bus.data_in  = 2'b01;
        tick();
        tick();
        check("ovf_set",      bus.overflow,  1'b1);
        check("ovf_cnt_hold", bus.sym_cnt,   2'd3);
        check("ovf_data",     bus.data_out,  8'h39);
        check("ovf_valid",    bus.valid_out, 1'b1);
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b1;
        #1;
        check("bp_release_ready", bus.ready_in, 1'b1);
        send(2'b11);
        check("bp_word_ff",    bus.data_out,  8'hFF);
        check("bp_valid_ff",   bus.valid_out, 1'b1);
        send(2'b00); send(2'b01); send(2'b10); send(2'b11);
        check("ovf_clean_word", bus.data_out, 8'hE4);
        bus.valid_in = 1'b0;
        tick();
        check("ovf_sticky", bus.overflow, 1'b1);

        // Test 6: reset with a partial word and a held word
        bus.ready_out = 1'b0;
        send(2'b01); send(2'b01); send(2'b01); send(2'b01);
        send(2'b10); send(2'b10);
        check("mid_cnt",   bus.sym_cnt,   2'd2);
        check("mid_valid", bus.valid_out, 1'b1);
        reset        = 1'b1;
        bus.valid_in = 1'b1;
        bus.data_in  = 2'b11;
        tick();
        sb.delete();
        acc  = '0;
        nsym = 0;
        check("mid_rst_valid", bus.valid_out, 1'b0);
        check("mid_rst_cnt",   bus.sym_cnt,   2'd0);
        check("mid_rst_ovf",   bus.overflow,  1'b0);
        check("mid_rst_data",  bus.data_out,  8'h00);
        reset         = 1'b0;
        bus.ready_out = 1'b1;
        send(2'b11); send(2'b10); send(2'b01); send(2'b00);
        check("post_rst_word",  bus.data_out,  8'h1B);
        check("post_rst_valid", bus.valid_out, 1'b1);
        bus.valid_in = 1'b0;
        tick();
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
